// File: rtl/befehl_holen_if.sv
// Fetch-unit bus: the RAM read port plus the instruction hand-off to the decoder.
// master = fetch unit (befehl_holen), slave = RAM/decoder side.
interface befehl_holen_if #(
  parameter int WORDSIZE = 32,
  parameter int AW       = 5
);
  logic                LesenAn;
  logic [AW-1:0]       Adresse;
  logic [WORDSIZE-1:0] DatenRaus;
  logic                DatenBereit;
  logic [WORDSIZE-1:0] Befehl;
  logic [AW-1:0]       BefehlAdresse;
  logic                BefehlGueltig;
  logic                BefehlAngenommen;
  logic                Sprung;
  logic [AW-1:0]       SprungZiel;

  modport master (
    output LesenAn, Adresse, Befehl, BefehlAdresse, BefehlGueltig,
    input  DatenRaus, DatenBereit, BefehlAngenommen, Sprung, SprungZiel
  );

  modport slave (
    input  LesenAn, Adresse, Befehl, BefehlAdresse, BefehlGueltig,
    output DatenRaus, DatenBereit, BefehlAngenommen, Sprung, SprungZiel
  );
endinterface

// File: rtl/befehl_holen.sv
// Instruction fetch unit: one outstanding RAM read, small instruction buffer, jump flush.
// Define BEFEHL_VORHOLEN_EN for a 2-entry prefetch buffer (default: 1 entry).
module befehl_holen #(
  parameter int WORDSIZE      = 32,
  parameter int WORDS         = 32,
  parameter int START_ADRESSE = 0
) (
  input logic            Clock,
  input logic            Reset_n,
  befehl_holen_if.master bus
);
  localparam int AW = $clog2(WORDS);
`ifdef BEFEHL_VORHOLEN_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [AW-1:0] START = AW'(START_ADRESSE);
  localparam logic [AW-1:0] LAST  = AW'(WORDS - 1);
  localparam logic [1:0]    FULL  = 2'(DEPTH);

  typedef enum logic [1:0] {LEERLAUF, ANFRAGE, WARTEN, VOLL} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       pc_q, pc_d, adr_q, adr_d;
  logic                lesen_q, lesen_d;
  logic                pend_q, pend_d, disc_q, disc_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [WORDSIZE-1:0] hd_dat_q, hd_dat_d;
  logic [AW-1:0]       hd_adr_q, hd_adr_d;
`ifdef BEFEHL_VORHOLEN_EN
  logic [WORDSIZE-1:0] nx_dat_q, nx_dat_d;
  logic [AW-1:0]       nx_adr_q, nx_adr_d;
`endif
  logic                xfer, cap;
  logic [1:0]          slot;

  always_comb begin
    xfer    = (cnt_q != 2'd0) && bus.BefehlAngenommen;
    // pend_q marks a read whose response is still due; disc_q marks it as stale
    cap     = bus.DatenBereit && pend_q && !disc_q;
    slot    = cnt_q - {1'b0, xfer};
    pend_d  = lesen_q || (pend_q && !bus.DatenBereit);
    disc_d  = disc_q && pend_d;
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = slot + {1'b0, cap};
    hd_dat_d = hd_dat_q;
    hd_adr_d = hd_adr_q;
`ifdef BEFEHL_VORHOLEN_EN
    nx_dat_d = nx_dat_q;
    nx_adr_d = nx_adr_q;
    if (xfer) begin
      hd_dat_d = nx_dat_q;
      hd_adr_d = nx_adr_q;
    end
    if (cap && slot == 2'd1) begin
      nx_dat_d = bus.DatenRaus;
      nx_adr_d = adr_q;
    end
`endif
    if (cap && slot == 2'd0) begin
      hd_dat_d = bus.DatenRaus;
      hd_adr_d = adr_q;
    end

    unique case (state_q)
      LEERLAUF: state_d = ANFRAGE;
      ANFRAGE: begin
        // without lesen_q we are still waiting for a discarded response
        if (lesen_q) begin
          state_d = WARTEN;
          pc_d    = (pc_q == LAST) ? '0 : pc_q + 1'b1;
        end
      end
      WARTEN:  if (cap) state_d = (cnt_d == FULL) ? VOLL : ANFRAGE;
      VOLL:    if (xfer) state_d = ANFRAGE;
      default: state_d = LEERLAUF;
    endcase

    if (bus.Sprung) begin
      state_d = ANFRAGE;
      pc_d    = bus.SprungZiel;
      cnt_d   = '0;
      disc_d  = pend_d;
    end

    lesen_d = (state_d == ANFRAGE) && !pend_d;
    adr_d   = lesen_d ? pc_d : adr_q;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= LEERLAUF;
      pc_q     <= START;
      adr_q    <= START;
      lesen_q  <= 1'b0;
      pend_q   <= 1'b0;
      disc_q   <= 1'b0;
      cnt_q    <= '0;
      hd_dat_q <= '0;
      hd_adr_q <= '0;
`ifdef BEFEHL_VORHOLEN_EN
      nx_dat_q <= '0;
      nx_adr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      adr_q    <= adr_d;
      lesen_q  <= lesen_d;
      pend_q   <= pend_d;
      disc_q   <= disc_d;
      cnt_q    <= cnt_d;
      hd_dat_q <= hd_dat_d;
      hd_adr_q <= hd_adr_d;
`ifdef BEFEHL_VORHOLEN_EN
      nx_dat_q <= nx_dat_d;
      nx_adr_q <= nx_adr_d;
`endif
    end
  end

  assign bus.LesenAn       = lesen_q;
  assign bus.Adresse       = adr_q;
  assign bus.Befehl        = hd_dat_q;
  assign bus.BefehlAdresse = hd_adr_q;
  assign bus.BefehlGueltig = (cnt_q != 2'd0);
endmodule

// File: doc/befehl_holen.md
BEFEHL_HOLEN -- requirements
Module: befehl_holen

Interface
REQ-001 SHALL have parameter WORDSIZE, default 32, instruction and memory word width.
REQ-002 SHALL have parameter WORDS, default 32, memory depth; AW = $clog2(WORDS).
REQ-003 SHALL have parameter START_ADRESSE, default 0, first fetch address after reset.
REQ-004 Clock  in  1  single clock, all state updates on rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 LesenAn  out  1  read request to the instruction RAM.
REQ-007 Adresse  out  AW  word address to the instruction RAM.
REQ-008 DatenRaus  in  WORDSIZE  read data from the RAM.
REQ-009 DatenBereit  in  1  RAM read-data-valid, high one cycle after a sampled LesenAn.
REQ-010 Befehl  out  WORDSIZE  instruction presented to the decoder.
REQ-011 BefehlAdresse  out  AW  address Befehl was fetched from.
REQ-012 BefehlGueltig  out  1  Befehl/BefehlAdresse valid.
REQ-013 BefehlAngenommen  in  1  decoder accepts; transfer on an edge with BefehlGueltig=1 and BefehlAngenommen=1.
REQ-014 Sprung  in  1  redirect fetch (jump/branch taken).
REQ-015 SprungZiel  in  AW  redirect target, sampled when Sprung=1.

Function
REQ-016 SHALL keep program counter PC (AW bits), incrementing by 1 per issued read, wrapping WORDS-1 -> 0.
REQ-017 SHALL use states LEERLAUF, ANFRAGE, WARTEN, VOLL.
REQ-018 LEERLAUF: one cycle after reset release, then ANFRAGE.
REQ-019 ANFRAGE: LesenAn=1 and Adresse=PC for exactly one cycle, then WARTEN; PC increments on that edge.
REQ-020 WARTEN: LesenAn=0; on the edge with DatenBereit=1, SHALL capture DatenRaus and its address into the buffer.
REQ-021 Latency: LesenAn asserted cycle N -> BefehlGueltig=1 from cycle N+2.
REQ-022 Buffer full and no acceptance -> VOLL; LesenAn stays 0; Befehl and BefehlAdresse SHALL remain stable while BefehlGueltig=1 and not accepted.
REQ-023 On a transfer, head SHALL be removed; if a buffer slot is free, next state ANFRAGE.
REQ-024 At most one read SHALL be outstanding at any time.
REQ-025 DatenBereit while no read outstanding SHALL be ignored.
REQ-026 Sprung=1 on an edge: PC := SprungZiel, buffer flushed (BefehlGueltig=0 next cycle), next state ANFRAGE; Sprung has priority over every other event.
REQ-027 Sprung while a read is outstanding: the response (next DatenBereit pulse) SHALL be discarded, and no new LesenAn SHALL be issued until it has arrived.
REQ-028 Sprung together with a transfer: the transfer counts as completed; the flush then applies.
REQ-029 Sprung in consecutive cycles: last SprungZiel wins.

Reset
REQ-030 Reset_n=0 SHALL immediately force: state LEERLAUF, PC=START_ADRESSE, LesenAn=0, Adresse=START_ADRESSE, BefehlGueltig=0, Befehl=0, BefehlAdresse=0, buffer empty, discard flag clear.
REQ-031 Reset asserted mid-read: the pending RAM response after reset release SHALL be ignored (REQ-025).

Configuration
REQ-032 Macro BEFEHL_VORHOLEN_EN.
REQ-033 Defined: 2-entry FIFO buffer; ANFRAGE is entered on the same edge a response is captured if one slot stays free -> sustained 1 instruction per 2 cycles; VOLL only with 2 entries held.
REQ-034 Undefined: 1-entry buffer; next ANFRAGE only after the held instruction is transferred -> at best 1 instruction per 3 cycles.

Verification
REQ-035 Reset release, RAM[0..2]=A,B,C, BefehlAngenommen=1 always -> Befehl A@0, B@1, C@2 in order; first BefehlGueltig 3 cycles after Reset_n rises; gap 3 cycles (2 with BEFEHL_VORHOLEN_EN).
REQ-036 BefehlAngenommen=0 for 10 cycles -> Befehl stable, LesenAn=0 after buffer full, no address skipped once accepted.
REQ-037 Sprung with SprungZiel=5 in the cycle after LesenAn for address 2 -> word 2 never presented; next BefehlAdresse=5.
REQ-038 WORDS=32, PC=31 -> fetch sequence 31, 0, 1.
REQ-039 Reset_n pulsed low during WARTEN -> all outputs at reset values; first Befehl after release from START_ADRESSE; stale DatenBereit ignored.
